// File: rtl/request_capture_4ch_if.sv
// Request/acknowledge bundle between the request sources, the capture stage and the 4-bit encoder.
// The master drives requests and acks; the slave is the capture stage.
interface request_capture_4ch_if;
    logic [3:0] req_in;
    logic       ack;
    logic [1:0] ack_idx;
    logic       ovf_clr;
    logic [3:0] pending;
    logic       any_pending;
    logic [3:0] overflow;

    modport master (
        output req_in, ack, ack_idx, ovf_clr,
        input  pending, any_pending, overflow
    );

    modport slave (
        input  req_in, ack, ack_idx, ovf_clr,
        output pending, any_pending, overflow
    );
endinterface

// File: rtl/request_capture_4ch.sv
// Capture stage for four asynchronous request lines: synchronise, detect rising edges,
// hold each request in a sticky pending bit until acked, and flag lost requests.
module request_capture_4ch #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    request_capture_4ch_if.slave  bus
);

    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic [3:0]                  prev_q, prev_d;
    logic [3:0]                  pending_q, pending_d;
    logic [3:0]                  overflow_q, overflow_d;

    logic [3:0] s;
    logic [3:0] rise;
    logic [3:0] clr;
    logic [3:0] ovf_set;

    // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], bus.req_in};
        s          = sync_q[SYNC_STAGES-1];
        prev_d     = s;
        rise       = s & ~prev_q;
        clr        = bus.ack ? (4'(1) << bus.ack_idx) : 4'b0000;
        // A fresh edge outranks the ack for its own channel, so it is never dropped.
        pending_d  = rise | (pending_q & ~clr);
        ovf_set    = rise & pending_q & ~clr;
        overflow_d = ovf_set | (bus.ovf_clr ? 4'b0000 : overflow_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            prev_q     <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.pending     = pending_q;
    assign bus.any_pending = |pending_q;
    assign bus.overflow    = overflow_q;

endmodule
